// File: rtl/dm_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory.
// slave = arbiter side; master = requesters plus the memory model that drives dm_rdata.
interface dm_arbiter_if #(
  parameter int IDX_W = 10
);
  logic             cpu_req;
  logic             cpu_we;
  logic [31:0]      cpu_addr;
  logic [31:0]      cpu_wdata;
  logic [3:0]       cpu_wstrb;
  logic             cpu_done;
  logic [31:0]      cpu_rdata;
  logic             cpu_err;
  logic             cpu_stall;

  logic             dbg_req;
  logic             dbg_we;
  logic [31:0]      dbg_addr;
  logic [31:0]      dbg_wdata;
  logic [3:0]       dbg_wstrb;
  logic             dbg_done;
  logic [31:0]      dbg_rdata;
  logic             dbg_err;

  logic             dm_en;
  logic [3:0]       dm_wea;
  logic [IDX_W-1:0] dm_addr;
  logic [31:0]      dm_wdata;
  logic [31:0]      dm_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_done, cpu_rdata, cpu_err, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wstrb,
    output dbg_done, dbg_rdata, dbg_err,
    output dm_en, dm_wea, dm_addr, dm_wdata,
    input  dm_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_done, cpu_rdata, cpu_err, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wstrb,
    input  dbg_done, dbg_rdata, dbg_err,
    input  dm_en, dm_wea, dm_addr, dm_wdata,
    output dm_rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// CPU/debug arbiter and 3-state sequencer (IDLE, ACCESS, RESP) for a synchronous data memory.
// Define DM_ARB_DBG_EN to enable the debug port with round-robin arbitration.
module dm_arbiter #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic         clk,
  input  logic         rstn,
  dm_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [30:0] DEPTH_LIM = 31'(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic        sel_we_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic [3:0]  sel_wstrb_s;
  logic        in_range_s;
  logic [31:0] resp_rdata_s;
  logic        unused_s;

`ifdef DM_ARB_DBG_EN
  logic        owner_q, owner_d;
  logic        lw_q, lw_d;

  // Command of the current owner feeds the memory and the response path.
  always_comb begin
    if (owner_q) begin
      sel_we_s    = bus.dbg_we;
      sel_addr_s  = bus.dbg_addr;
      sel_wdata_s = bus.dbg_wdata;
      sel_wstrb_s = bus.dbg_wstrb;
    end else begin
      sel_we_s    = bus.cpu_we;
      sel_addr_s  = bus.cpu_addr;
      sel_wdata_s = bus.cpu_wdata;
      sel_wstrb_s = bus.cpu_wstrb;
    end
  end

  assign unused_s = ^{sel_addr_s[1:0]};
`else
  assign sel_we_s    = bus.cpu_we;
  assign sel_addr_s  = bus.cpu_addr;
  assign sel_wdata_s = bus.cpu_wdata;
  assign sel_wstrb_s = bus.cpu_wstrb;
  assign unused_s    = ^{sel_addr_s[1:0], bus.dbg_req, bus.dbg_we, bus.dbg_addr,
                         bus.dbg_wdata, bus.dbg_wstrb};
`endif

  assign in_range_s   = ({1'b0, sel_addr_s[31:2]} < DEPTH_LIM);
  assign resp_rdata_s = (err_q || sel_we_s) ? 32'h0000_0000 : bus.dm_rdata;

  // State, owner, last-winner and error flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
`ifdef DM_ARB_DBG_EN
      owner_q <= 1'b0;
      lw_q    <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
`ifdef DM_ARB_DBG_EN
      owner_q <= owner_d;
      lw_q    <= lw_d;
`endif
    end
  end

  // Next state: arbitration happens only in IDLE, so a stale req during RESP is never re-granted.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
`ifdef DM_ARB_DBG_EN
    owner_d = owner_q;
    lw_d    = lw_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef DM_ARB_DBG_EN
        if (bus.cpu_req && bus.dbg_req) begin
          owner_d = ~lw_q;
          lw_d    = ~lw_q;
          state_d = ST_ACCESS;
        end else if (bus.cpu_req) begin
          owner_d = 1'b0;
          lw_d    = 1'b0;
          state_d = ST_ACCESS;
        end else if (bus.dbg_req) begin
          owner_d = 1'b1;
          lw_d    = 1'b1;
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
`else
        if (bus.cpu_req) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
`endif
      end
      ST_ACCESS: begin
        err_d   = ~in_range_s;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory drive in ACCESS and owner response in RESP; everything else held at zero.
  always_comb begin
    bus.dm_en     = 1'b0;
    bus.dm_wea    = 4'b0000;
    bus.dm_addr   = {IDX_W{1'b0}};
    bus.dm_wdata  = 32'h0000_0000;
    bus.cpu_done  = 1'b0;
    bus.cpu_rdata = 32'h0000_0000;
    bus.cpu_err   = 1'b0;
    bus.dbg_done  = 1'b0;
    bus.dbg_rdata = 32'h0000_0000;
    bus.dbg_err   = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        bus.dm_addr  = sel_addr_s[IDX_W+1:2];
        bus.dm_wdata = sel_wdata_s;
        if (in_range_s) begin
          bus.dm_en  = 1'b1;
          bus.dm_wea = sel_we_s ? sel_wstrb_s : 4'b0000;
        end else begin
          bus.dm_en  = 1'b0;
          bus.dm_wea = 4'b0000;
        end
      end
      ST_RESP: begin
`ifdef DM_ARB_DBG_EN
        if (owner_q) begin
          bus.dbg_done  = 1'b1;
          bus.dbg_rdata = resp_rdata_s;
          bus.dbg_err   = err_q;
        end else begin
          bus.cpu_done  = 1'b1;
          bus.cpu_rdata = resp_rdata_s;
          bus.cpu_err   = err_q;
        end
`else
        bus.cpu_done  = 1'b1;
        bus.cpu_rdata = resp_rdata_s;
        bus.cpu_err   = err_q;
`endif
      end
      default: begin
        bus.dm_en = 1'b0;
      end
    endcase
  end

  assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_done;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: stimulus pushes expected responses, a negedge monitor pops
// and compares on every done pulse. Debug-port scenarios follow the DM_ARB_DBG_EN build.
module tb_dm_arbiter;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic rstn;
  int   total;
  int   bad;
  int   cyc;
  int   cpu_done_cyc;
  int   dbg_done_cyc;
  int   dbg_done_cnt;
  exp_t cpu_q[$];
  exp_t dbg_q[$];
  logic [31:0] mem [0:1023];

  dm_arbiter_if #(.IDX_W(10)) bus ();

  dm_arbiter #(.DEPTH_WORDS(1024)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port memory, registered read.
  always @(posedge clk) begin
    if (bus.dm_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.dm_wea[b]) mem[bus.dm_addr][8*b +: 8] <= bus.dm_wdata[8*b +: 8];
      end
      bus.dm_rdata <= mem[bus.dm_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the front of that port's expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (bus.cpu_done) begin
        cpu_done_cyc = cyc;
        if (cpu_q.size() == 0) begin
          chk("cpu_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = cpu_q.pop_front();
          chk("cpu_rdata", bus.cpu_rdata, e.rdata);
          chk("cpu_err", {31'b0, bus.cpu_err}, {31'b0, e.err});
        end
      end else begin
        chk("cpu_quiet_out", {bus.cpu_rdata[31:1], bus.cpu_rdata[0] | bus.cpu_err}, 32'h0);
      end
      if (bus.dbg_done) begin
        dbg_done_cyc = cyc;
        dbg_done_cnt++;
        if (dbg_q.size() == 0) begin
          chk("dbg_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = dbg_q.pop_front();
          chk("dbg_rdata", bus.dbg_rdata, e.rdata);
          chk("dbg_err", {31'b0, bus.dbg_err}, {31'b0, e.err});
        end
      end else begin
        chk("dbg_quiet_out", {bus.dbg_rdata[31:1], bus.dbg_rdata[0] | bus.dbg_err}, 32'h0);
      end
    end
  end

  task automatic drive(input bit port, input bit req, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    if (port) begin
      bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = addr;
      bus.dbg_wdata = wdata; bus.dbg_wstrb = wstrb;
    end else begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr;
      bus.cpu_wdata = wdata; bus.cpu_wstrb = wstrb;
    end
  endtask

  task automatic push_exp(input bit port, input logic [31:0] rd, input bit err);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    if (port) dbg_q.push_back(e);
    else cpu_q.push_back(e);
  endtask

  // One uncontended access; checks the memory drive in ACCESS, latency and stall length.
  task automatic single_access(input bit port, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb,
                               input logic [31:0] exp_rd, input bit exp_err, input bit exp_en,
                               input logic [3:0] exp_wea, input logic [9:0] exp_dma);
    int k;
    int stall_cnt;
    bit seen;
    @(posedge clk); #1;
    drive(port, 1'b1, we, addr, wdata, wstrb);
    push_exp(port, exp_rd, exp_err);
    k = 0; stall_cnt = 0; seen = 1'b0;
    while (!seen && k < 12) begin
      @(negedge clk);
      if (k == 1) begin
        chk("acc_dm_en", {31'b0, bus.dm_en}, {31'b0, exp_en});
        chk("acc_dm_wea", {28'b0, bus.dm_wea}, {28'b0, exp_wea});
        chk("acc_dm_addr", {22'b0, bus.dm_addr}, {22'b0, exp_dma});
        chk("acc_dm_wdata", bus.dm_wdata, wdata);
      end else begin
        chk("nonacc_dm_bus", {bus.dm_en, bus.dm_wea, bus.dm_addr} | bus.dm_wdata, 32'h0);
      end
      if (bus.cpu_stall) stall_cnt++;
      if (port ? bus.dbg_done : bus.cpu_done) begin
        seen = 1'b1;
        chk("done_latency", k, 32'd2);
      end
      k++;
    end
    chk("done_seen", {31'b0, seen}, 32'd1);
    if (!port) chk("stall_cycles", stall_cnt, 32'd2);
    @(posedge clk); #1;
    drive(port, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
  endtask

  // Bounded wait for a port's done, then release that port's request.
  task automatic wait_done_release(input bit port);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (port ? bus.dbg_done : bus.cpu_done) seen = 1'b1;
    end
    chk(port ? "dbg_done_seen" : "cpu_done_seen", {31'b0, seen}, 32'd1);
    @(posedge clk); #1;
    drive(port, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rp;
    total = 0; bad = 0; cyc = 0; dbg_done_cnt = 0;
    cpu_done_cyc = 0; dbg_done_cyc = 0;
    rstn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);

    // Reset state
    #3;
    chk("rst_cpu_out", {bus.cpu_done, bus.cpu_err, bus.cpu_stall} | bus.cpu_rdata, 32'h0);
    chk("rst_dbg_out", {bus.dbg_done, bus.dbg_err} | bus.dbg_rdata, 32'h0);
    chk("rst_dm_bus", {bus.dm_en, bus.dm_wea, bus.dm_addr} | bus.dm_wdata, 32'h0);
    bus.cpu_req = 1'b1;
    #1;
    chk("rst_stall_follows_req", {31'b0, bus.cpu_stall}, 32'd1);
    bus.cpu_req = 1'b0;
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;

    // Full-word store then load back
    single_access(1'b0, 1'b1, 32'h10, 32'hA5A5A5A5, 4'b1111, 32'h0, 1'b0, 1'b1, 4'b1111, 10'd4);
    single_access(1'b0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hA5A5A5A5, 1'b0, 1'b1, 4'b0000, 10'd4);
    // Byte-lane merge
    single_access(1'b0, 1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h0, 1'b0, 1'b1, 4'b1111, 10'd8);
    single_access(1'b0, 1'b1, 32'h22, 32'h00CD0000, 4'b0100, 32'h0, 1'b0, 1'b1, 4'b0100, 10'd8);
    single_access(1'b0, 1'b0, 32'h20, 32'h0, 4'b0000, 32'h11CD3344, 1'b0, 1'b1, 4'b0000, 10'd8);
    // Last in-range word
    single_access(1'b0, 1'b1, 32'hFFC, 32'h5A5A0FF0, 4'b1111, 32'h0, 1'b0, 1'b1, 4'b1111, 10'h3FF);
    single_access(1'b0, 1'b0, 32'hFFC, 32'h0, 4'b0000, 32'h5A5A0FF0, 1'b0, 1'b1, 4'b0000, 10'h3FF);
    // First out-of-range word: load and store both report err without touching memory
    single_access(1'b0, 1'b0, 32'h1000, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b0, 4'b0000, 10'd0);
    single_access(1'b0, 1'b1, 32'h1004, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1, 1'b0, 4'b0000, 10'd1);
    single_access(1'b0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hA5A5A5A5, 1'b0, 1'b1, 4'b0000, 10'd4);

`ifdef DM_ARB_DBG_EN
    // Simultaneous requests: CPU first, DBG exactly 3 cycles later
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b0000);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'b0000);
    push_exp(1'b0, 32'hA5A5A5A5, 1'b0);
    push_exp(1'b1, 32'h11CD3344, 1'b0);
    fork
      wait_done_release(1'b0);
      wait_done_release(1'b1);
    join
    chk("dbg_after_cpu", dbg_done_cyc - cpu_done_cyc, 32'd3);
    single_access(1'b1, 1'b0, 32'hFFC, 32'h0, 4'b0000, 32'h5A5A0FF0, 1'b0, 1'b1, 4'b0000, 10'h3FF);
    rp = 1'b1;
`else
    // Debug port disabled: a held dbg_req is never served
    dbg_done_cnt = 0;
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'b0000);
    single_access(1'b0, 1'b0, 32'h20, 32'h0, 4'b0000, 32'h11CD3344, 1'b0, 1'b1, 4'b0000, 10'd8);
    repeat (6) @(negedge clk);
    chk("dbg_never_done", dbg_done_cnt, 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
    rp = 1'b0;
`endif

    // Reset pulsed in the middle of an ACCESS cycle of a store
    @(posedge clk); #1;
    drive(rp, 1'b1, 1'b1, 32'h30, 32'hDEADBEEF, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_dm_en", {31'b0, bus.dm_en}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_dm_drop", {27'b0, bus.dm_en, bus.dm_wea}, 32'h0);
    chk("rst_mid_no_done", {30'b0, bus.cpu_done, bus.dbg_done}, 32'h0);
    @(posedge clk); #1;
    drive(rp, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
    @(negedge clk);
    chk("rst_hold_no_done", {30'b0, bus.cpu_done, bus.dbg_done}, 32'h0);
    rstn = 1'b1;
    single_access(1'b0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hA5A5A5A5, 1'b0, 1'b1, 4'b0000, 10'd4);

    repeat (3) @(negedge clk);
    chk("cpu_q_drained", cpu_q.size(), 32'd0);
    chk("dbg_q_drained", dbg_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and sequencer for the pipeline's synchronous single-port data memory. It shares the memory between the CPU MEM stage (port 0) and an external debug/loader port (port 1). Byte strobes and aligned write data arrive already formatted by the load/store formatting logic. The block runs a fixed 3-state access sequence and stalls the pipeline while a CPU access is pending. Out-of-range accesses complete with an error flag and never touch memory.

## Interface
Parameters:
- DEPTH_WORDS, 1024, memory depth in 32-bit words; must be a power of two, minimum 2
- IDX_W, $clog2(DEPTH_WORDS), memory word-index width (derived)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rstn  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held high with its command stable until cpu_done
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address; bits [1:0] ignored
- cpu_wdata  in  32  lane-aligned store data
- cpu_wstrb  in  4  byte-lane write enables
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read word; valid only while cpu_done=1, otherwise 0
- cpu_err  out  1  out-of-range flag; valid only with cpu_done
- cpu_stall  out  1  cpu_req & ~cpu_done
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wstrb, dbg_done, dbg_rdata, dbg_err  same widths and rules as the cpu_* ports
- dm_en  out  1  memory enable
- dm_wea  out  4  memory byte write enables
- dm_addr  out  IDX_W  memory word index, taken from addr[IDX_W+1:2]
- dm_wdata  out  32  memory write data
- dm_rdata  in  32  memory read data, valid one cycle after the dm_en edge

## Operation
- The FSM has three states: IDLE, ACCESS, RESP. An owner register (0 = CPU, 1 = DBG) and a last-winner pointer `lw` complete the state.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: that port wins.
  - Both request: the port other than `lw` wins (round-robin).
  - On a win: latch owner, set `lw` = winner, go to ACCESS.
- ACCESS (one cycle):
  - dm_addr and dm_wdata come from the owner's inputs.
  - In range (addr[31:2] < DEPTH_WORDS): dm_en=1; dm_wea = we ? wstrb : 4'b0000.
  - Out of range: dm_en=0, dm_wea=0; latch err=1.
  - Always go to RESP.
- RESP (one cycle):
  - Owner's done=1.
  - Owner's rdata = (err or we) ? 0 : dm_rdata. Owner's err = latched err.
  - Always return to IDLE.
- Outside ACCESS: dm_en=0, dm_wea=0, dm_addr=0, dm_wdata=0.
- The non-owner's done, rdata and err are always 0.
- A requester must drop req, or present a new command, on the cycle after done. Because RESP never re-arbitrates, the owner's stale req is never re-granted.
- Changing a held command before done is a protocol violation; the result is undefined.

## Timing
- Reset (asynchronous): state=IDLE, owner=0, `lw`=1 (CPU wins the first tie), err=0. All outputs are 0 except cpu_stall, which follows cpu_req.
- Reset asserted in ACCESS: dm_en and dm_wea drop immediately; the memory write is not guaranteed to complete; no done pulse is issued.
- Latency: req sampled high in IDLE at edge N → ACCESS in cycle N+1 → done in cycle N+2 → IDLE in cycle N+3.
- One access occupies 3 cycles. Maximum throughput is one access per 3 cycles.
- With both ports continuously requesting, grants alternate CPU, DBG, CPU, …; neither port waits more than 6 cycles.
- A request arriving while another access is in ACCESS or RESP waits for the next IDLE.
- cpu_stall is combinational and deasserts in the cycle cpu_done=1.

## Configuration
- Macro: DM_ARB_DBG_EN.
- Defined: two-port round-robin behaviour as described above.
- Undefined:
  - All dbg_* inputs are ignored; dbg_done, dbg_rdata and dbg_err are tied to 0.
  - Only the CPU is ever granted; `lw` is removed.
  - CPU latency is unchanged (3 cycles).

## Test plan
- Reset, then CPU store addr=0x10, wdata=0xA5A5A5A5, wstrb=4'b1111, followed by a load from 0x10 → ACCESS cycle shows dm_en=1, dm_wea=1111, dm_addr=4; the load returns cpu_rdata=0xA5A5A5A5 with cpu_done at N+2 and cpu_stall high for 2 cycles.
- CPU and DBG both request on the same edge after reset → CPU granted first, DBG second; dbg_done occurs exactly 3 cycles after cpu_done.
- Byte store wstrb=4'b0100, wdata=0x00CD0000 at addr 0x22 over a word holding 0x11223344 → dm_wea=0100; a later word load reads 0x11CD3344.
- CPU load at addr=0x00001000 with DEPTH_WORDS=1024 → dm_en stays 0; cpu_done=1, cpu_err=1, cpu_rdata=0.
- rstn pulsed low during ACCESS of a DBG store → dm_en/dm_wea drop without waiting for a clock edge; no dbg_done is issued; after release the FSM is in IDLE and a CPU request completes in 3 cycles.
- Build without DM_ARB_DBG_EN, hold dbg_req=1 and issue a CPU load → dbg_done never asserts; CPU load completes normally.
